reg_wb_arbiter: RTL and testbench
=================================

// Module: reg_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (RegWEn/addrD/dataD) between the ALU writeback and the load-return unit.
//  Keeps a per-register scoreboard of outstanding loads.
//  Tells decode when rs1/rs2 read a register whose load data has not yet been written.
//  Sits between the EX/MEM stages and the register file.
// PARAMETERS
//  DATA_LENGTH      32  writeback data width
//  REG_ADDR_LENGTH  5   register address width
//  REG_COUNT        32  number of architectural registers
//  STARVE_LIMIT     4   consecutive lost arbitrations before a waiting load is forced through (>=1)
// PORTS
//  clk          in   1    clock, all state on posedge
//  rst_n        in   1    asynchronous reset, active low
//  alu_valid    in   1    ALU writeback request
//  alu_ready    out  1    ALU request granted this cycle
//  alu_rd       in   REG_ADDR_LENGTH  ALU destination register
//  alu_data     in   DATA_LENGTH      ALU result
//  ld_valid     in   1    load-return writeback request
//  ld_ready     out  1    load request granted this cycle
//  ld_rd        in   REG_ADDR_LENGTH  load destination register
//  ld_data      in   DATA_LENGTH      load data
//  ld_issue     in   1    a load to ld_issue_rd is issued to memory this cycle
//  ld_issue_rd  in   REG_ADDR_LENGTH  destination of the issuing load
//  ld_issue_ok  out  1    0 when the count for ld_issue_rd is saturated; issue must be held off
//  rs1_addr     in   REG_ADDR_LENGTH  decode source 1
//  rs2_addr     in   REG_ADDR_LENGTH  decode source 2
//  hazard       out  1    rs1 or rs2 has an outstanding load; decode stalls
//  RegWEn       out  1    register-file write enable
//  addrD        out  REG_ADDR_LENGTH  register-file write address
//  dataD        out  DATA_LENGTH      register-file write data
// BEHAVIOUR
//  Reset: RegWEn=0, addrD=0, dataD=0, FSM=ALU_PRI, starve_cnt=0, all scoreboard counts=0. Async assert, sync release.
//  Reset mid-operation: the write registered but not committed is dropped and the scoreboard is cleared.
//  Handshakes: a transfer happens when valid && ready. ready is combinational from valid and state. Requesters hold rd/data stable until granted.
//  Arbitration, FSM states:
//   ALU_PRI: ALU wins if alu_valid; otherwise load wins if ld_valid.
//    Each cycle both are valid and the load loses, starve_cnt++.
//    When a loss brings starve_cnt to STARVE_LIMIT, go to LD_FORCE.
//    Any load grant clears starve_cnt.
//   LD_FORCE: load wins if ld_valid, then go to ALU_PRI with starve_cnt=0.
//    If ld_valid drops, go to ALU_PRI.
//  Output stage: the grant at cycle N drives RegWEn/addrD/dataD registered at N+1. Latency 1; one write per cycle max.
//   Idle cycle: RegWEn=0; addrD/dataD hold their last value.
//  x0: a grant with rd==0 is consumed and ready is asserted, but RegWEn stays 0.
//  Scoreboard: 2-bit saturating count per register; x0 is never counted.
//   Increment on ld_issue && ld_issue_ok && ld_issue_rd!=0.
//   Decrement on the edge that ends a cycle where RegWEn=1 and the registered write came from the load port (internal wb_src flag), using addrD.
//   Increment and decrement on the same register in the same cycle: count unchanged.
//   ld_issue_ok = (count[ld_issue_rd] != 3).
//  hazard = (rs1_addr!=0 && count[rs1_addr]!=0) || (rs2_addr!=0 && count[rs2_addr]!=0). Combinational.
//   hazard drops in the cycle after the load write commits, when the register file already holds the data.
//  ALU writes do not touch the scoreboard.
//  A write to a register with pending loads is a pipeline ordering error; this block does not check it.
// STRUCTURE
//  Shared package rv_pkg:
//   DATA_LENGTH, REG_ADDR_LENGTH, REG_COUNT constants
//   wb_src enum {WB_ALU, WB_LD}
//   arb_state enum {ALU_PRI, LD_FORCE}
//  One sub-module, ld_scoreboard: count array, issue/commit update, the two hazard lookups and ld_issue_ok.
//  Arbiter FSM and output registers stay in the top level.
// TESTING
//  1 ALU only: alu_valid, rd=5, data=0xDEADBEEF -> alu_ready same cycle; next cycle RegWEn=1, addrD=5, dataD=0xDEADBEEF.
//  2 Contention, STARVE_LIMIT=4: alu_valid and ld_valid held high for 6 cycles ->
//     ALU granted on cycles 0-3, load on cycle 4, ALU on cycle 5; starve_cnt back to 0.
//  3 Scoreboard: ld_issue rd=7, then rs1_addr=7 -> hazard=1.
//     Load returns rd=7 and is granted at N -> hazard=1 through N+1, hazard=0 at N+2.
//  4 Saturation: three ld_issue to rd=3 -> ld_issue_ok=0.
//     Issue and load commit to rd=3 in the same cycle -> count stays 3.
//  5 x0: ALU grant rd=0 and ld_issue rd=0 -> ready=1, RegWEn stays 0, hazard=0 for rs1=0.
//  6 Reset mid-operation: rst_n low while a load write is registered and count[9]=2 ->
//     RegWEn=0 immediately and hazard=0 for rs1=9 after release.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types and widths for the writeback path and load scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: data/address widths, register count, writeback source and arbiter state enums,
//           scoreboard counter type and its saturation value.
package rv_pkg;

  localparam int DATA_LENGTH     = 32;
  localparam int REG_ADDR_LENGTH = 5;
  localparam int REG_COUNT       = 32;

  typedef enum logic {WB_ALU, WB_LD} wb_src_t;
  typedef enum logic {ALU_PRI, LD_FORCE} arb_state_t;

  typedef logic [1:0] sb_cnt_t;
  localparam sb_cnt_t SB_MAX = 2'd3;

endpackage

// File: rtl/ld_scoreboard.sv
// Per-register count of outstanding loads; flags decode hazards and gates new load issue.
// Latency: issue/commit update the counts on the next edge; hazard and issue_ok are combinational.
// Backpressure: issue_ok_o low when the destination count is saturated.
// Ports: clk, rst_n; issue_vld_i/issue_rd_i (load sent to memory); commit_vld_i/commit_rd_i
//        (load data written to the register file); rs1_addr_i/rs2_addr_i; issue_ok_o; hazard_o.
module ld_scoreboard
  import rv_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_vld_i,
  input  logic [REG_ADDR_LENGTH-1:0] issue_rd_i,
  input  logic                       commit_vld_i,
  input  logic [REG_ADDR_LENGTH-1:0] commit_rd_i,
  input  logic [REG_ADDR_LENGTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_LENGTH-1:0] rs2_addr_i,
  output logic                       issue_ok_o,
  output logic                       hazard_o
);

  sb_cnt_t cnt_q [REG_COUNT];
  sb_cnt_t cnt_d [REG_COUNT];

  always_comb begin
    cnt_d = cnt_q;
    // x0 is never tracked, so entry 0 is left at zero.
    for (int r = 1; r < REG_COUNT; r++) begin
      // An issue and a commit landing on the same register cancel, even when the
      // count is saturated: the outstanding total is unchanged either way.
      if (issue_vld_i && (issue_rd_i == REG_ADDR_LENGTH'(r)) &&
          commit_vld_i && (commit_rd_i == REG_ADDR_LENGTH'(r))) begin
        cnt_d[r] = cnt_q[r];
      end else if (issue_vld_i && (issue_rd_i == REG_ADDR_LENGTH'(r)) &&
                   (cnt_q[r] != SB_MAX)) begin
        cnt_d[r] = cnt_q[r] + 2'd1;
      end else if (commit_vld_i && (commit_rd_i == REG_ADDR_LENGTH'(r)) &&
                   (cnt_q[r] != 2'd0)) begin
        // Guarded against underflow; a commit with nothing pending is an upstream error.
        cnt_d[r] = cnt_q[r] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign issue_ok_o = (cnt_q[issue_rd_i] != SB_MAX);
  assign hazard_o   = ((rs1_addr_i != '0) && (cnt_q[rs1_addr_i] != 2'd0)) ||
                      ((rs2_addr_i != '0) && (cnt_q[rs2_addr_i] != 2'd0));

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU writeback and load return.
// Latency: grant is combinational; the register-file write is registered one cycle after grant.
// Backpressure: alu_ready/ld_ready low for the losing requester; loads are forced through after STARVE_LIMIT losses.
// Ports: clk, rst_n; alu_valid/alu_ready/alu_rd/alu_data; ld_valid/ld_ready/ld_rd/ld_data;
//        ld_issue/ld_issue_rd/ld_issue_ok; rs1_addr/rs2_addr/hazard; RegWEn/addrD/dataD.
module reg_wb_arbiter
  import rv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [REG_ADDR_LENGTH-1:0] alu_rd,
  input  logic [DATA_LENGTH-1:0]     alu_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [REG_ADDR_LENGTH-1:0] ld_rd,
  input  logic [DATA_LENGTH-1:0]     ld_data,
  input  logic                       ld_issue,
  input  logic [REG_ADDR_LENGTH-1:0] ld_issue_rd,
  output logic                       ld_issue_ok,
  input  logic [REG_ADDR_LENGTH-1:0] rs1_addr,
  input  logic [REG_ADDR_LENGTH-1:0] rs2_addr,
  output logic                       hazard,
  output logic                       RegWEn,
  output logic [REG_ADDR_LENGTH-1:0] addrD,
  output logic [DATA_LENGTH-1:0]     dataD
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t                 state_q, state_d;
  logic [SW-1:0]              starve_q, starve_d;
  logic                       wen_q, wen_d;
  logic [REG_ADDR_LENGTH-1:0] addr_q, addr_d;
  logic [DATA_LENGTH-1:0]     data_q, data_d;
  wb_src_t                    src_q, src_d;

  // Arbitration FSM: ready depends only on the valids and the current state.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    case (state_q)
      ALU_PRI: begin
        alu_ready = alu_valid;
        ld_ready  = ld_valid && !alu_valid;
        if (alu_valid && ld_valid) begin
          starve_d = starve_q + 1'b1;
          if (starve_d == SW'(STARVE_LIMIT)) state_d = LD_FORCE;
        end
        if (ld_ready) starve_d = '0;
      end
      LD_FORCE: begin
        // The load owns this cycle; the ALU only uses the port if the load went away.
        ld_ready  = ld_valid;
        alu_ready = alu_valid && !ld_valid;
        state_d   = ALU_PRI;
        starve_d  = '0;
      end
      default: begin
        state_d  = ALU_PRI;
        starve_d = '0;
      end
    endcase
  end

  // Write stage: x0 grants are consumed without a write, and address/data
  // only move on a real write so they hold through idle cycles.
  always_comb begin
    wen_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    src_d  = src_q;
    if (ld_ready && (ld_rd != '0)) begin
      wen_d  = 1'b1;
      addr_d = ld_rd;
      data_d = ld_data;
      src_d  = WB_LD;
    end else if (alu_ready && (alu_rd != '0)) begin
      wen_d  = 1'b1;
      addr_d = alu_rd;
      data_d = alu_data;
      src_d  = WB_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ALU_PRI;
      starve_q <= '0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      src_q    <= WB_ALU;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      src_q    <= src_d;
    end
  end

  assign RegWEn = wen_q;
  assign addrD  = addr_q;
  assign dataD  = data_q;

  // The load's count is released on the edge that commits its data, so decode
  // sees the hazard clear only once the register file holds the value.
  ld_scoreboard u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_vld_i  (ld_issue),
    .issue_rd_i   (ld_issue_rd),
    .commit_vld_i (wen_q && (src_q == WB_LD)),
    .commit_rd_i  (addr_q),
    .rs1_addr_i   (rs1_addr),
    .rs2_addr_i   (rs2_addr),
    .issue_ok_o   (ld_issue_ok),
    .hazard_o     (hazard)
  );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus random traffic
// against a transaction-level model of loss counting, outstanding loads and the write stage.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_reg_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_valid, ld_issue;
  logic        alu_ready, ld_ready, ld_issue_ok, hazard, RegWEn;
  logic [4:0]  alu_rd, ld_rd, ld_issue_rd, rs1_addr, rs2_addr, addrD;
  logic [31:0] alu_data, ld_data, dataD;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ok(ld_issue_ok),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard),
    .RegWEn(RegWEn), .addrD(addrD), .dataD(dataD)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_cnt [32];   // loads issued but not yet committed, saturating at 3
  int          owed  [32];   // loads issued but not yet granted on the return port
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_src_ld;
  int          m_loss;       // consecutive losses of a waiting load
  logic        e_ga, e_gl;
  logic        obs_ar, obs_lr, obs_ok, obs_hz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = 0;
      owed[i]  = 0;
    end
    m_wen = 1'b0; m_addr = '0; m_data = '0; m_src_ld = 1'b0; m_loss = 0;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
  endtask

  // Called 1ns after a rising edge with inputs already driven; returns 1ns after the next edge.
  task automatic cycle();
    logic forced, ga, gl, ok, hz;
    int   dec_r;
    #1;
    forced = (m_loss == LIMIT);
    if (forced) begin
      gl = ld_valid;
      ga = alu_valid && !ld_valid;
    end else begin
      ga = alu_valid;
      gl = ld_valid && !alu_valid;
    end
    ok = (m_cnt[ld_issue_rd] != 3);
    hz = (rs1_addr != 0 && m_cnt[rs1_addr] != 0) || (rs2_addr != 0 && m_cnt[rs2_addr] != 0);
    chk("alu_ready", 32'(alu_ready), 32'(ga));
    chk("ld_ready", 32'(ld_ready), 32'(gl));
    chk("ld_issue_ok", 32'(ld_issue_ok), 32'(ok));
    chk("hazard", 32'(hazard), 32'(hz));
    chk("RegWEn", 32'(RegWEn), 32'(m_wen));
    chk("addrD", 32'(addrD), 32'(m_addr));
    chk("dataD", dataD, m_data);
    obs_ar = alu_ready; obs_lr = ld_ready; obs_ok = ld_issue_ok; obs_hz = hazard;
    e_ga = ga; e_gl = gl;

    // Outstanding-load bookkeeping for the coming edge.
    dec_r = (m_wen && m_src_ld) ? int'(m_addr) : -1;
    if (ld_issue && ld_issue_rd != 0) begin
      if (int'(ld_issue_rd) == dec_r) begin
        owed[ld_issue_rd]++;
        dec_r = -1;
      end else if (m_cnt[ld_issue_rd] != 3) begin
        m_cnt[ld_issue_rd]++;
        owed[ld_issue_rd]++;
      end
    end
    if (dec_r > 0 && m_cnt[dec_r] > 0) m_cnt[dec_r]--;
    if (gl && ld_rd != 0) owed[ld_rd]--;

    // Register-file write one cycle after the grant.
    if (gl && ld_rd != 0) begin
      m_wen = 1'b1; m_addr = ld_rd; m_data = ld_data; m_src_ld = 1'b1;
    end else if (ga && alu_rd != 0) begin
      m_wen = 1'b1; m_addr = alu_rd; m_data = alu_data; m_src_ld = 1'b0;
    end else begin
      m_wen = 1'b0;
    end

    if (forced) m_loss = 0;
    else begin
      if (alu_valid && ld_valid) m_loss++;
      if (gl) m_loss = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit   alu_pend, ld_pend, found;
    int   r;
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", 32'(RegWEn), 32'd0);
    chk("rst_addr", 32'(addrD), 32'd0);
    chk("rst_data", dataD, 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    rst_n = 1'b1;

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    cycle();
    chk("t1_ready", 32'(obs_ar), 32'd1);
    chk("t1_wen", 32'(RegWEn), 32'd1);
    chk("t1_addr", 32'(addrD), 32'd5);
    chk("t1_data", dataD, 32'hDEADBEEF);
    idle();

    // Contention: the load wins only after four straight losses
    ld_issue = 1'b1; ld_issue_rd = 5'd12;
    cycle();
    idle();
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = $urandom;
      ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h0C0C_0000 + i;
      cycle();
      chk($sformatf("t2_ld_ready%0d", i), 32'(obs_lr), 32'(i == 4));
      chk($sformatf("t2_alu_ready%0d", i), 32'(obs_ar), 32'(i != 4));
    end
    idle();

    // Hazard lifetime across a load
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    cycle();
    idle(); rs1_addr = 5'd7;
    cycle();
    chk("t3_hz_issued", 32'(obs_hz), 32'd1);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h7777_7777;
    cycle();
    chk("t3_grant", 32'(obs_lr), 32'd1);
    chk("t3_hz_n", 32'(obs_hz), 32'd1);
    ld_valid = 1'b0;
    cycle();
    chk("t3_hz_n1", 32'(obs_hz), 32'd1);
    cycle();
    chk("t3_hz_n2", 32'(obs_hz), 32'd0);
    idle();

    // Saturation at three outstanding loads
    ld_issue = 1'b1; ld_issue_rd = 5'd3;
    repeat (3) cycle();
    ld_issue = 1'b0;
    cycle();
    chk("t4_sat", 32'(obs_ok), 32'd0);
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h3333_0001;
    cycle();
    ld_valid = 1'b0; ld_issue = 1'b1;
    cycle();
    ld_issue = 1'b0;
    cycle();
    chk("t4_still_sat", 32'(obs_ok), 32'd0);
    idle();

    // x0 traffic
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234_5678;
    ld_issue = 1'b1; ld_issue_rd = 5'd0;
    cycle();
    chk("t5_ready", 32'(obs_ar), 32'd1);
    chk("t5_hz", 32'(obs_hz), 32'd0);
    chk("t5_wen", 32'(RegWEn), 32'd0);
    idle();

    // Reset with a load write in flight
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    repeat (2) cycle();
    idle();
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9999_9999;
    cycle();
    idle();
    chk("t6_pre_wen", 32'(RegWEn), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_wen_async", 32'(RegWEn), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rs1_addr = 5'd9;
    cycle();
    chk("t6_hz", 32'(obs_hz), 32'd0);
    idle();

    // Random traffic; requesters hold rd/data until granted
    alu_pend = 1'b0; ld_pend = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!alu_pend) begin
        alu_valid = ($urandom_range(0, 9) < 8);
        alu_rd = 5'($urandom_range(0, 15));
        alu_data = $urandom;
      end
      if (!ld_pend) begin
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
          r = $urandom_range(1, 15);
          if (owed[r] > 0) found = 1'b1;
        end
        ld_valid = found && ($urandom_range(0, 2) != 0);
        ld_rd = found ? 5'(r) : 5'd0;
        ld_data = $urandom;
      end
      ld_issue = ($urandom_range(0, 2) == 0);
      ld_issue_rd = 5'($urandom_range(0, 15));
      rs1_addr = 5'($urandom_range(0, 15));
      rs2_addr = 5'($urandom_range(0, 15));
      cycle();
      alu_pend = alu_valid && !e_ga;
      ld_pend  = ld_valid && !e_gl;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
